// File: rtl/rv_fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
// Holds the fetch FSM encoding and the word-alignment constants.
package rv_fetch_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_OUT   = 2'd2,
    ST_DRAIN = 2'd3
  } fetch_state_t;

  localparam int INST_BYTES = 4;
  localparam int ALIGN_BITS = $clog2(INST_BYTES);
  localparam logic [ALIGN_BITS-1:0] ALIGN_ZERO = '0;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Bundle of redirect, instruction-memory and decode-side signals of the fetch unit.
// master = fetch unit; slave = environment (memory, decode, branch unit).
interface pc_fetch_unit_if #(
  parameter int XLEN = 32,
  parameter int ILEN = 32
);
  // Handshakes: imem request transfers when imem_req && imem_gnt on a rising edge;
  // imem_rvalid returns exactly one response per granted request; the decode
  // transfer happens when out_valid && out_ready, and out_inst/out_pc hold while stalled.
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            redirect_misaligned;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [ILEN-1:0] imem_rdata;

  logic            out_valid;
  logic            out_ready;
  logic [ILEN-1:0] out_inst;
  logic [XLEN-1:0] out_pc;

  modport master (
    input  redirect_valid, redirect_pc,
    output redirect_misaligned,
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    output out_valid, out_inst, out_pc,
    input  out_ready
  );

  modport slave (
    output redirect_valid, redirect_pc,
    input  redirect_misaligned,
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    input  out_valid, out_inst, out_pc,
    output out_ready
  );

endinterface

// File: rtl/pc_reg.sv
// Program counter register: reset vector, redirect load and +4 step.
// The load value arrives already word aligned.
module pc_reg
  import rv_fetch_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_load,
  input  logic [XLEN-1:0] i_load_pc,
  input  logic            i_inc,
  output logic [XLEN-1:0] o_pc
);

  logic [XLEN-1:0] r_pc;

  // Redirect outranks the increment; the add wraps naturally at 2^XLEN.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= RESET_VECTOR;
    end else if (i_load) begin
      r_pc <= i_load_pc;
    end else if (i_inc) begin
      r_pc <= r_pc + XLEN'(INST_BYTES);
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch unit: issues one imem read at a time and buffers the returned word for decode.
// Redirects retarget the PC and discard any response already in flight.
module pc_fetch_unit
  import rv_fetch_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter int              ILEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  pc_fetch_unit_if.master        bus,
  output fetch_state_t           o_dbg_state
);

  fetch_state_t    r_state;
  logic            r_imem_req;
  logic            r_out_valid;
  logic [ILEN-1:0] r_out_inst;
  logic [XLEN-1:0] r_out_pc;
  logic            r_misaligned;

  logic [XLEN-1:0] w_pc;
  logic [XLEN-1:0] w_redirect_target;
  logic            w_granted;
  logic            w_pc_inc;

  assign w_redirect_target = {bus.redirect_pc[XLEN-1:ALIGN_BITS], ALIGN_ZERO};
  // A grant only counts while the request is actually being driven.
  assign w_granted = (r_state == ST_FETCH) && r_imem_req && bus.imem_gnt;
  assign w_pc_inc  = (r_state == ST_WAIT) && bus.imem_rvalid && !bus.redirect_valid;

  pc_reg #(
    .XLEN         (XLEN),
    .RESET_VECTOR (RESET_VECTOR)
  ) u_pc_reg (
    .clk       (clk),
    .reset     (reset),
    .i_load    (bus.redirect_valid),
    .i_load_pc (w_redirect_target),
    .i_inc     (w_pc_inc),
    .o_pc      (w_pc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_FETCH;
      r_imem_req   <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_inst   <= '0;
      r_out_pc     <= '0;
      r_misaligned <= 1'b0;
    end else begin
      r_misaligned <= bus.redirect_valid && (|bus.redirect_pc[ALIGN_BITS-1:0]);
      if (bus.redirect_valid) begin
        // Held instruction is dropped; only an outstanding request forces a drain.
        r_out_valid <= 1'b0;
        case (r_state)
          ST_FETCH: begin
            r_state    <= w_granted ? ST_DRAIN : ST_FETCH;
            r_imem_req <= !w_granted;
          end
          ST_WAIT: begin
            r_state    <= bus.imem_rvalid ? ST_FETCH : ST_DRAIN;
            r_imem_req <= bus.imem_rvalid;
          end
          ST_OUT: begin
            r_state    <= ST_FETCH;
            r_imem_req <= 1'b1;
          end
          ST_DRAIN: begin
            r_state    <= bus.imem_rvalid ? ST_FETCH : ST_DRAIN;
            r_imem_req <= bus.imem_rvalid;
          end
        endcase
      end else begin
        case (r_state)
          ST_FETCH: begin
            r_state    <= w_granted ? ST_WAIT : ST_FETCH;
            r_imem_req <= !w_granted;
          end
          ST_WAIT: begin
            if (bus.imem_rvalid) begin
              r_out_inst  <= bus.imem_rdata;
              r_out_pc    <= w_pc;
              r_out_valid <= 1'b1;
              r_state     <= ST_OUT;
            end
          end
          ST_OUT: begin
            if (bus.out_ready) begin
              r_out_valid <= 1'b0;
              r_imem_req  <= 1'b1;
              r_state     <= ST_FETCH;
            end
          end
          ST_DRAIN: begin
            if (bus.imem_rvalid) begin
              r_imem_req <= 1'b1;
              r_state    <= ST_FETCH;
            end
          end
        endcase
      end
    end
  end

  assign bus.imem_req            = r_imem_req;
  assign bus.imem_addr           = w_pc;
  assign bus.out_valid           = r_out_valid;
  assign bus.out_inst            = r_out_inst;
  assign bus.out_pc              = r_out_pc;
  assign bus.redirect_misaligned = r_misaligned;
  assign o_dbg_state             = r_state;

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Parametrised successor to the team's reset/increment program-counter test block.
- Holds the RISC-V PC, issues instruction-memory reads with a req/gnt/rvalid handshake, and presents fetched instructions to decode through a one-entry valid/ready buffer.
- Adds reset vector, redirects for branch/jump, discard of stale in-flight responses, and misalignment flagging.
- Sits between the instruction memory and the decode stage.

Parameters:
- XLEN, 32, PC/address width in bits; must be at least 8.
- ILEN, 32, instruction word width.
- RESET_VECTOR, 0, PC value loaded on reset; bits [1:0] must be 0.

Ports:
- clk in 1: clock; all state updates on the rising edge.
- reset in 1: synchronous, active-high reset.
- redirect_valid in 1: load a new PC this cycle (branch/jump/trap).
- redirect_pc in XLEN: target PC.
- imem_req out 1: read request.
- imem_addr out XLEN: read address, word aligned.
- imem_gnt in 1: memory accepted the request this cycle.
- imem_rvalid in 1: read data valid.
- imem_rdata in ILEN: read data.
- out_valid out 1: fetched instruction available to decode.
- out_ready in 1: decode accepts the instruction.
- out_inst out ILEN: instruction word.
- out_pc out XLEN: address of out_inst.
- redirect_misaligned out 1: one-cycle pulse; redirect_pc[1:0] was nonzero.

Behaviour:
- Reset, synchronous and active-high:
  - pc=RESET_VECTOR; state=FETCH.
  - imem_req=0, out_valid=0, out_inst=0, out_pc=0, redirect_misaligned=0 in the cycle after reset is sampled.
  - reset overrides every other input, including in mid-transaction. The instruction memory shares this reset and drops any outstanding response.
- States: FETCH, WAIT, OUT, DRAIN.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - imem_gnt=1 -> WAIT. Otherwise hold the request with imem_addr stable.
- WAIT:
  - imem_req=0.
  - imem_rvalid=1 -> out_inst<=imem_rdata, out_pc<=pc, pc<=pc+4 (modulo 2^XLEN; wraps from all-ones minus 3 to 0), go to OUT.
- OUT:
  - out_valid=1; out_inst and out_pc stay stable while out_ready=0.
  - out_ready=1 -> FETCH; out_valid is 0 the next cycle.
  - Throughput is one instruction per 3 cycles with a single-cycle memory. A bubble is acceptable.
- DRAIN:
  - imem_req=0; wait for the stale imem_rvalid and discard its data.
  - pc is unchanged on that response; then go to FETCH.
- redirect_valid=1 has priority over every normal transition:
  - pc<={redirect_pc[XLEN-1:2],2'b00}; redirect_misaligned<=|redirect_pc[1:0] for one cycle.
  - out_valid is forced to 0 next cycle; any instruction held in OUT is dropped, even if out_ready=1 in the same cycle.
  - Next state depends on the current state:
    - FETCH with imem_gnt=0 -> FETCH (new address next cycle).
    - FETCH with imem_gnt=1 -> DRAIN.
    - WAIT with imem_rvalid=0 -> DRAIN.
    - WAIT with imem_rvalid=1 -> FETCH (response discarded).
    - OUT -> FETCH.
    - DRAIN -> DRAIN. A simultaneous rvalid is still discarded, and the state returns to FETCH only once no response is outstanding.
- A redirect in the same cycle as the drained response completes the drain and goes to FETCH with the new pc.
- Consecutive redirects: the last one wins.
- At most one request is outstanding at any time.
- imem_rvalid outside WAIT/DRAIN is ignored.

Decomposition:
- Package rv_fetch_pkg holds:
  - the state enum fetch_state_t;
  - INST_BYTES=4;
  - localparam helpers for word alignment.
- One natural sub-module, pc_reg: the PC register with reset vector, +4 increment and redirect load.
- The FSM and output buffer stay in pc_fetch_unit.

Test Plan:
- Reset and first fetch:
  - Stimulus: hold reset 4 cycles, RESET_VECTOR=32'h0000_0100; then release reset with memory gnt=1, rvalid=1 one cycle later returning 32'h0000_0013, and out_ready=1.
  - Response: during reset imem_req=0 and out_valid=0. After release, imem_addr=0x100; out_inst=0x13, out_pc=0x100; the next imem_addr=0x104.
- Backpressure:
  - Stimulus: out_ready=0 for 5 cycles in OUT.
  - Response: out_valid stays 1, out_inst and out_pc stay unchanged, imem_req=0. Raising out_ready advances the fetch to the next address.
- Redirect while waiting:
  - Stimulus: redirect_pc=0x200 in WAIT, stale rvalid data=0xDEAD_BEEF arriving next cycle.
  - Response: stale data never appears on out_inst. The next imem_addr=0x200.
- Misaligned redirect:
  - Stimulus: redirect_pc=0x303 in FETCH with gnt=0.
  - Response: redirect_misaligned pulses once; next imem_addr=0x300.
- Wrap-around:
  - Stimulus: XLEN=8, redirect to 0xFC.
  - Response: after the fetch completes, imem_addr=0x00.
- Reset mid-operation:
  - Stimulus: assert reset in OUT with out_valid=1.
  - Response: the next cycle has out_valid=0, imem_req=0 and pc=RESET_VECTOR.
